// File: rtl/sfx_pkg.sv
// sfx_pkg: shared types and constants for the pong sound-effect sequencer.
//   - sfx_state_e : sequencer states (IDLE, PADDLE, WALL, SCORE_HI, SCORE_LO)
//   - PRIO_*      : sound priorities, IDLE counts as 0
//   - DEF_*       : default tone half-periods (clk cycles) and lengths (frames)
//   - state_prio  : maps a state to its priority
package sfx_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PADDLE   = 3'd1,
    WALL     = 3'd2,
    SCORE_HI = 3'd3,
    SCORE_LO = 3'd4
  } sfx_state_e;

  localparam logic [1:0] PRIO_IDLE   = 2'd0;
  localparam logic [1:0] PRIO_WALL   = 2'd1;
  localparam logic [1:0] PRIO_PADDLE = 2'd2;
  localparam logic [1:0] PRIO_SCORE  = 2'd3;

  localparam logic [15:0] DEF_PADDLE_HALF   = 16'd32768;
  localparam logic [15:0] DEF_WALL_HALF     = 16'd16384;
  localparam logic [15:0] DEF_SCORE_HI_HALF = 16'd12288;
  localparam logic [15:0] DEF_SCORE_LO_HALF = 16'd49152;

  localparam int DEF_PADDLE_FRAMES = 4;
  localparam int DEF_WALL_FRAMES   = 2;
  localparam int DEF_SCORE_FRAMES  = 8;

  function automatic logic [1:0] state_prio(input sfx_state_e s);
    case (s)
      PADDLE:             state_prio = PRIO_PADDLE;
      WALL:               state_prio = PRIO_WALL;
      SCORE_HI, SCORE_LO: state_prio = PRIO_SCORE;
      default:            state_prio = PRIO_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/sfx_tone.sv
// sfx_tone: 16-bit half-period divider driving a registered square wave.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   restart    : start a fresh note -> counter 0, sq 1 on the next edge
//   enable     : low forces counter 0 and sq 0 (silence)
//   half[15:0] : half-period in clk cycles for the note being played
//   sq         : square-wave output (registered)
module sfx_tone (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        restart,
  input  logic        enable,
  input  logic [15:0] half,
  output logic        sq
);

  logic [15:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sq  <= 1'b0;
    end else if (restart) begin
      cnt <= '0;
      sq  <= 1'b1;
    end else if (!enable) begin
      cnt <= '0;
      sq  <= 1'b0;
    end else if (cnt == half - 16'd1) begin
      cnt <= '0;
      sq  <= ~sq;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/sfx_sequencer.sv
// sfx_sequencer: plays fixed-length, frame-timed tones on pong game events.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   frame_tick  : one-cycle pulse per video frame
//   evt_paddle  : paddle hit pulse   (priority 2)
//   evt_wall    : wall bounce pulse  (priority 1)
//   evt_score   : point scored pulse (priority 3, two-note jingle)
//   audio_out   : mono square-wave audio
//   busy        : high while a sound is playing (registered)
// Build option: define SFX_DECAY_EN to gate the last frame of every note with
// a 25% duty PWM, giving an audible decay. Undefined -> plain square wave.
module sfx_sequencer
  import sfx_pkg::*;
#(
  parameter logic [15:0] PADDLE_HALF   = DEF_PADDLE_HALF,
  parameter logic [15:0] WALL_HALF     = DEF_WALL_HALF,
  parameter logic [15:0] SCORE_HI_HALF = DEF_SCORE_HI_HALF,
  parameter logic [15:0] SCORE_LO_HALF = DEF_SCORE_LO_HALF,
  parameter int          PADDLE_FRAMES = DEF_PADDLE_FRAMES,
  parameter int          WALL_FRAMES   = DEF_WALL_FRAMES,
  parameter int          SCORE_FRAMES  = DEF_SCORE_FRAMES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_tick,
  input  logic evt_paddle,
  input  logic evt_wall,
  input  logic evt_score,
  output logic audio_out,
  output logic busy
);

  localparam logic [3:0] F_PADDLE = 4'(PADDLE_FRAMES);
  localparam logic [3:0] F_WALL   = 4'(WALL_FRAMES);
  localparam logic [3:0] F_SCORE  = 4'(SCORE_FRAMES);

  sfx_state_e  state, state_nxt, evt_state;
  logic [3:0]  frames_left, frames_nxt, evt_frames;
  logic [1:0]  evt_prio;
  logic        accept, restart, tone_en;
  logic [15:0] half;
  logic        sq;

  // Arbitration, frame countdown and next state.
  always_comb begin
    evt_state  = IDLE;
    evt_prio   = PRIO_IDLE;
    evt_frames = '0;
    if (evt_score) begin
      evt_state  = SCORE_HI;
      evt_prio   = PRIO_SCORE;
      evt_frames = F_SCORE;
    end else if (evt_paddle) begin
      evt_state  = PADDLE;
      evt_prio   = PRIO_PADDLE;
      evt_frames = F_PADDLE;
    end else if (evt_wall) begin
      evt_state  = WALL;
      evt_prio   = PRIO_WALL;
      evt_frames = F_WALL;
    end

    // >= lets a sound retrigger itself; lower priorities are simply dropped.
    accept = (evt_prio != PRIO_IDLE) && (evt_prio >= state_prio(state));

    state_nxt  = state;
    frames_nxt = frames_left;
    restart    = 1'b0;
    // An accepted event overrides a same-cycle frame_tick entirely.
    if (accept) begin
      state_nxt  = evt_state;
      frames_nxt = evt_frames;
      restart    = 1'b1;
    end else if (frame_tick && state != IDLE) begin
      if (frames_left == 4'd1) begin
        if (state == SCORE_HI) begin
          state_nxt  = SCORE_LO;
          frames_nxt = F_SCORE;
          restart    = 1'b1;
        end else begin
          state_nxt  = IDLE;
          frames_nxt = '0;
        end
      end else begin
        frames_nxt = frames_left - 4'd1;
      end
    end

    // Leaving for IDLE silences the tone on the same edge busy drops.
    tone_en = (state_nxt != IDLE);
  end

  // Half-period of the note now playing; on a restart edge it is unused.
  always_comb begin
    half = PADDLE_HALF;
    case (state)
      PADDLE:   half = PADDLE_HALF;
      WALL:     half = WALL_HALF;
      SCORE_HI: half = SCORE_HI_HALF;
      SCORE_LO: half = SCORE_LO_HALF;
      default:  half = PADDLE_HALF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      frames_left <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      frames_left <= frames_nxt;
      busy        <= (state_nxt != IDLE);
    end
  end

  sfx_tone u_tone (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .enable  (tone_en),
    .half    (half),
    .sq      (sq)
  );

`ifdef SFX_DECAY_EN
  logic [1:0] pwm_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_cnt <= '0;
    else        pwm_cnt <= pwm_cnt + 2'd1;
  end

  // frames_left is 0 in IDLE, so the gate only ever acts on a note's last frame.
  assign audio_out = (frames_left == 4'd1) ? (sq & (pwm_cnt == 2'd0)) : sq;
`else
  assign audio_out = sq;
`endif

endmodule

// File: tb/tb_sfx_sequencer.sv
// tb_sfx_sequencer: directed test of sfx_sequencer with shortened tones.
// PADDLE half 4 / 2 frames, WALL half 6 / 2 frames, SCORE half 3 and 5 / 3 frames.
module tb_sfx_sequencer;
  import sfx_pkg::*;

  logic clk, rst_n, frame_tick, evt_paddle, evt_wall, evt_score;
  logic audio_out, busy;
  int total = 0;
  int bad = 0;
  int cyc_cnt = 0;

  sfx_sequencer #(
    .PADDLE_HALF(16'd4), .WALL_HALF(16'd6),
    .SCORE_HI_HALF(16'd3), .SCORE_LO_HALF(16'd5),
    .PADDLE_FRAMES(2), .WALL_FRAMES(2), .SCORE_FRAMES(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .evt_paddle(evt_paddle), .evt_wall(evt_wall), .evt_score(evt_score),
    .audio_out(audio_out), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_cnt++;
  endtask

  task automatic pulse(input logic p, input logic w, input logic s, input logic t);
    evt_paddle = p; evt_wall = w; evt_score = s; frame_tick = t;
    cyc();
    evt_paddle = 1'b0; evt_wall = 1'b0; evt_score = 1'b0; frame_tick = 1'b0;
  endtask

  task automatic tick();
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; frame_tick = 1'b0;
    evt_paddle = 1'b0; evt_wall = 1'b0; evt_score = 1'b0;
    #12;
    total++; if (audio_out !== 1'b0) begin bad++; $display("FAIL reset_audio got=%b exp=0", audio_out); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst_n = 1'b1;
    cyc(); cyc();
    total++; if (dut.state !== IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", dut.state, IDLE); end
    total++; if (dut.frames_left !== 4'd0) begin bad++; $display("FAIL reset_frames got=%0d exp=0", dut.frames_left); end
    // Ticks in IDLE do nothing.
    tick();
    total++; if (busy !== 1'b0 || audio_out !== 1'b0) begin bad++; $display("FAIL idle_tick busy=%b audio=%b exp=0/0", busy, audio_out); end
  endtask

  task automatic test_paddle_tone();
    int e;
    logic exp_a;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    e = cyc_cnt;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL pad_entry_busy got=%b exp=1", busy); end
    total++; if (audio_out !== 1'b1) begin bad++; $display("FAIL pad_entry_audio got=%b exp=1", audio_out); end
    total++; if (dut.frames_left !== 4'd2) begin bad++; $display("FAIL pad_entry_frames got=%0d exp=2", dut.frames_left); end
    for (int k = 1; k < 16; k++) begin
      cyc();
      exp_a = (((cyc_cnt - e) / 4) % 2) == 0;
      total++; if (audio_out !== exp_a) begin bad++; $display("FAIL pad_tone k=%0d got=%b exp=%b", k, audio_out, exp_a); end
    end
    tick();
    total++; if (busy !== 1'b1 || dut.frames_left !== 4'd1) begin bad++; $display("FAIL pad_tick1 busy=%b frames=%0d exp=1/1", busy, dut.frames_left); end
    tick();
    total++; if (busy !== 1'b0 || audio_out !== 1'b0 || dut.state !== IDLE) begin bad++; $display("FAIL pad_end busy=%b audio=%b state=%0d exp=0/0/IDLE", busy, audio_out, dut.state); end
    cyc(); cyc();
    total++; if (audio_out !== 1'b0) begin bad++; $display("FAIL idle_hold audio=%b exp=0", audio_out); end
  endtask

  task automatic test_simultaneous();
    bit saw_wall = 1'b0;
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    total++; if (dut.state !== PADDLE) begin bad++; $display("FAIL simul_state got=%0d exp=%0d", dut.state, PADDLE); end
    for (int k = 1; k <= 5; k++) begin
      cyc();
      if (dut.state == WALL) saw_wall = 1'b1;
      // Paddle half-period 4: low at k=4,5 (a wall tone would still be high).
      if (k == 4) begin
        total++; if (audio_out !== 1'b0) begin bad++; $display("FAIL simul_half got=%b exp=0", audio_out); end
      end
    end
    tick(); if (dut.state == WALL) saw_wall = 1'b1;
    tick(); if (dut.state == WALL) saw_wall = 1'b1;
    total++; if (saw_wall !== 1'b0 || dut.state !== IDLE) begin bad++; $display("FAIL simul_no_wall saw=%b state=%0d exp=0/IDLE", saw_wall, dut.state); end
  endtask

  task automatic test_wall();
    int e;
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    e = cyc_cnt;
    total++; if (dut.state !== WALL || audio_out !== 1'b1) begin bad++; $display("FAIL wall_entry state=%0d audio=%b exp=WALL/1", dut.state, audio_out); end
    while (cyc_cnt - e < 5) cyc();
    total++; if (audio_out !== 1'b1) begin bad++; $display("FAIL wall_k5 got=%b exp=1", audio_out); end
    cyc();
    total++; if (audio_out !== 1'b0) begin bad++; $display("FAIL wall_k6 got=%b exp=0", audio_out); end
    tick();
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    total++; if (dut.frames_left !== 4'd2 || audio_out !== 1'b1) begin bad++; $display("FAIL wall_retrig frames=%0d audio=%b exp=2/1", dut.frames_left, audio_out); end
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    total++; if (dut.state !== PADDLE) begin bad++; $display("FAIL wall_preempt state=%0d exp=%0d", dut.state, PADDLE); end
    tick(); tick();
    total++; if (dut.state !== IDLE || busy !== 1'b0) begin bad++; $display("FAIL wall_end state=%0d busy=%b exp=IDLE/0", dut.state, busy); end
  endtask

  task automatic test_priority();
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    total++; if (dut.state !== PADDLE || dut.frames_left !== 4'd1) begin bad++; $display("FAIL prio_wall_drop state=%0d frames=%0d exp=PADDLE/1", dut.state, dut.frames_left); end
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    total++; if (dut.state !== SCORE_HI || audio_out !== 1'b1 || dut.frames_left !== 4'd3) begin bad++; $display("FAIL prio_score_entry state=%0d audio=%b frames=%0d exp=HI/1/3", dut.state, audio_out, dut.frames_left); end
    tick(); tick();
    total++; if (dut.state !== SCORE_HI || dut.frames_left !== 4'd1) begin bad++; $display("FAIL score_hi_last state=%0d frames=%0d exp=HI/1", dut.state, dut.frames_left); end
    tick();
    total++; if (dut.state !== SCORE_LO || audio_out !== 1'b1 || dut.frames_left !== 4'd3 || busy !== 1'b1) begin bad++; $display("FAIL score_lo_entry state=%0d audio=%b frames=%0d busy=%b exp=LO/1/3/1", dut.state, audio_out, dut.frames_left, busy); end
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    total++; if (dut.state !== SCORE_LO || dut.frames_left !== 4'd3) begin bad++; $display("FAIL score_pad_drop state=%0d frames=%0d exp=LO/3", dut.state, dut.frames_left); end
    tick(); tick(); tick();
    total++; if (dut.state !== IDLE || audio_out !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL score_end state=%0d audio=%b busy=%b exp=IDLE/0/0", dut.state, audio_out, busy); end
  endtask

  task automatic test_tick_collision();
    int e;
    pulse(1'b1, 1'b0, 1'b0, 1'b1);
    total++; if (dut.state !== PADDLE || dut.frames_left !== 4'd2) begin bad++; $display("FAIL coll_entry state=%0d frames=%0d exp=PADDLE/2", dut.state, dut.frames_left); end
    tick();
    total++; if (dut.frames_left !== 4'd1) begin bad++; $display("FAIL coll_tick frames=%0d exp=1", dut.frames_left); end
    // Retrigger on the tick that would otherwise end the sound.
    pulse(1'b1, 1'b0, 1'b0, 1'b1);
    e = cyc_cnt;
    total++; if (dut.state !== PADDLE || dut.frames_left !== 4'd2 || audio_out !== 1'b1) begin bad++; $display("FAIL coll_retrig state=%0d frames=%0d audio=%b exp=PADDLE/2/1", dut.state, dut.frames_left, audio_out); end
    while (cyc_cnt - e < 3) cyc();
    total++; if (audio_out !== 1'b1) begin bad++; $display("FAIL coll_k3 got=%b exp=1", audio_out); end
    cyc();
    total++; if (audio_out !== 1'b0) begin bad++; $display("FAIL coll_k4 got=%b exp=0", audio_out); end
    tick(); tick();
    total++; if (dut.state !== IDLE) begin bad++; $display("FAIL coll_end state=%0d exp=IDLE", dut.state); end
  endtask

  task automatic test_async_reset();
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    tick(); tick(); tick();
    cyc();
    total++; if (dut.state !== SCORE_LO) begin bad++; $display("FAIL ar_pre state=%0d exp=LO", dut.state); end
    #3 rst_n = 1'b0;
    #1;
    total++; if (audio_out !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL ar_immediate audio=%b busy=%b exp=0/0", audio_out, busy); end
    #2 rst_n = 1'b1;
    cyc(); cyc(); cyc();
    total++; if (dut.state !== IDLE || busy !== 1'b0 || audio_out !== 1'b0 || dut.frames_left !== 4'd0) begin bad++; $display("FAIL ar_after state=%0d busy=%b audio=%b frames=%0d exp=IDLE/0/0/0", dut.state, busy, audio_out, dut.frames_left); end
  endtask

  task automatic test_last_frame();
    int e;
    logic exp_sq, exp_a;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    e = cyc_cnt;
    for (int k = 1; k < 8; k++) begin
      cyc();
      exp_a = (((cyc_cnt - e) / 4) % 2) == 0;
      total++; if (audio_out !== exp_a) begin bad++; $display("FAIL lf_early k=%0d got=%b exp=%b", k, audio_out, exp_a); end
    end
    tick();
    for (int k = 0; k < 8; k++) begin
      exp_sq = (((cyc_cnt - e) / 4) % 2) == 0;
`ifdef SFX_DECAY_EN
      exp_a = exp_sq & (dut.pwm_cnt == 2'd0);
`else
      exp_a = exp_sq;
`endif
      total++; if (audio_out !== exp_a) begin bad++; $display("FAIL lf_last k=%0d got=%b exp=%b", k, audio_out, exp_a); end
      cyc();
    end
    tick();
    total++; if (dut.state !== IDLE || audio_out !== 1'b0) begin bad++; $display("FAIL lf_end state=%0d audio=%b exp=IDLE/0", dut.state, audio_out); end
  endtask

  initial begin
    test_reset();
    test_paddle_tone();
    test_simultaneous();
    test_wall();
    test_priority();
    test_tick_collision();
    test_async_reset();
    test_last_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
